// File: rtl/gcd_rr_operand_mux_if.sv
// Operand-channel bundle between the N:1 operand selector and its sources/GCD core.
// master = selector side, slave = environment (sources and downstream core).
interface gcd_rr_operand_mux_if #(
  parameter int unsigned WID = 8,
  parameter int unsigned NCH = 4
);
  localparam int unsigned CH_W = $clog2(NCH);

  logic [NCH-1:0]     in_valid;
  logic [NCH*WID-1:0] in_data;
  logic [NCH-1:0]     in_ready;
  logic               o_valid;
  logic [WID-1:0]     o_data;
  logic [CH_W-1:0]    o_ch;
  logic               o_ready;

  modport master (
    input  in_valid, in_data, o_ready,
    output in_ready, o_valid, o_data, o_ch
  );

  modport slave (
    output in_valid, in_data, o_ready,
    input  in_ready, o_valid, o_data, o_ch
  );
endinterface

// File: rtl/gcd_rr_operand_mux.sv
// Registered N:1 operand selector for the GCD datapath: round-robin or fixed-priority
// arbitration into a one-entry output register with valid/ready and a channel tag.
module gcd_rr_operand_mux #(
  parameter int unsigned WID     = 8,
  parameter int unsigned NCH     = 4,
  parameter int unsigned RR_MODE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  gcd_rr_operand_mux_if.master io_bus
);
  localparam int unsigned CH_W = $clog2(NCH);

  logic [CH_W-1:0] r_ptr;
  logic            r_valid;
  logic [WID-1:0]  r_data;
  logic [CH_W-1:0] r_ch;

  logic [CH_W-1:0] w_ptr_nxt;
  logic            w_valid_nxt;
  logic [WID-1:0]  w_data_nxt;
  logic [CH_W-1:0] w_ch_nxt;
  logic [CH_W-1:0] w_base;
  logic [CH_W-1:0] w_grant;
  logic            w_any;
  logic            w_load_en;
  logic            w_xfer;
  logic [NCH-1:0]  w_ready;

  // Modulo-NCH add; wraps at NCH, not at 2^CH_W, so non-power-of-two NCH stays in range.
  function automatic logic [CH_W-1:0] wrap_idx(input logic [CH_W-1:0] base,
                                               input int unsigned    off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NCH) s = s - NCH;
    return CH_W'(s);
  endfunction

  assign w_base    = (RR_MODE != 0) ? r_ptr : '0;
  assign w_load_en = !r_valid || io_bus.o_ready;
  assign w_xfer    = w_load_en && w_any && !rst;

  // Scan from the base channel; first asserted valid wins.
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!w_any && io_bus.in_valid[wrap_idx(w_base, i)]) begin
        w_any   = 1'b1;
        w_grant = wrap_idx(w_base, i);
      end
    end
  end

  always_comb begin
    w_ready     = '0;
    w_valid_nxt = r_valid;
    w_data_nxt  = r_data;
    w_ch_nxt    = r_ch;
    w_ptr_nxt   = r_ptr;
    if (w_xfer) begin
      w_ready[w_grant] = 1'b1;
      w_valid_nxt      = 1'b1;
      w_data_nxt       = io_bus.in_data[32'(w_grant)*WID +: WID];
      w_ch_nxt         = w_grant;
      if (RR_MODE != 0) w_ptr_nxt = wrap_idx(w_grant, 1);
    end else if (r_valid && io_bus.o_ready) begin
      w_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ch    <= '0;
      r_ptr   <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      r_data  <= w_data_nxt;
      r_ch    <= w_ch_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  assign io_bus.in_ready = w_ready;
  assign io_bus.o_valid  = r_valid;
  assign io_bus.o_data   = r_data;
  assign io_bus.o_ch     = r_ch;
endmodule

// File: tb/tb_gcd_rr_operand_mux.sv
// Directed bench for gcd_rr_operand_mux: round-robin (NCH=4 and NCH=3) and fixed-priority instances.
module tb_gcd_rr_operand_mux;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  gcd_rr_operand_mux_if #(.WID(8), .NCH(4)) bus_r ();
  gcd_rr_operand_mux_if #(.WID(8), .NCH(4)) bus_f ();
  gcd_rr_operand_mux_if #(.WID(8), .NCH(3)) bus_3 ();

  gcd_rr_operand_mux #(.WID(8), .NCH(4), .RR_MODE(1)) dut_r (.clk(clk), .rst(rst), .io_bus(bus_r));
  gcd_rr_operand_mux #(.WID(8), .NCH(4), .RR_MODE(0)) dut_f (.clk(clk), .rst(rst), .io_bus(bus_f));
  gcd_rr_operand_mux #(.WID(8), .NCH(3), .RR_MODE(1)) dut_3 (.clk(clk), .rst(rst), .io_bus(bus_3));

  localparam logic [31:0] STD_DATA = {8'h43, 8'h32, 8'h21, 8'h10};

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus_r.in_valid = 4'b1111;
    bus_r.in_data  = STD_DATA;
    #1;
    n_tests++; if (bus_r.in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0000", bus_r.in_ready); end
    step();
    n_tests++; if (bus_r.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_o_valid: got %b want 0", bus_r.o_valid); end
    n_tests++; if (bus_r.o_data !== 8'h00) begin n_fail++; $display("FAIL reset_o_data: got %h want 00", bus_r.o_data); end
    n_tests++; if (bus_r.o_ch !== 2'd0) begin n_fail++; $display("FAIL reset_o_ch: got %0d want 0", bus_r.o_ch); end
    rst = 1'b0;
    bus_r.in_valid = 4'b0010;
    step();
    n_tests++; if (bus_r.o_valid !== 1'b1 || bus_r.o_data !== 8'h21) begin n_fail++; $display("FAIL reset_preload: got v=%b d=%h want v=1 d=21", bus_r.o_valid, bus_r.o_data); end
    bus_r.in_valid = 4'b0001;
    bus_r.o_ready  = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_tests++; if (bus_r.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_async_valid: got %b want 0", bus_r.o_valid); end
    n_tests++; if (bus_r.o_data !== 8'h00 || bus_r.o_ch !== 2'd0) begin n_fail++; $display("FAIL reset_async_data: got d=%h ch=%0d want d=00 ch=0", bus_r.o_data, bus_r.o_ch); end
    bus_r.o_ready = 1'b1;
    #1;
    n_tests++; if (bus_r.in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_async_ready: got %b want 0000", bus_r.in_ready); end
    step();
    rst = 1'b0;
    bus_r.in_valid = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++; if (bus_r.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_idle_%0d: got o_valid=%b want 0", i, bus_r.o_valid); end
    end
  endtask

  task automatic test_single();
    do_reset();
    bus_r.o_ready  = 1'b1;
    bus_r.in_data  = {8'h43, 8'h3C, 8'h21, 8'h10};
    bus_r.in_valid = 4'b0100;
    #1;
    n_tests++; if (bus_r.in_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b want 0100", bus_r.in_ready); end
    step();
    n_tests++; if (bus_r.o_valid !== 1'b1 || bus_r.o_data !== 8'h3C || bus_r.o_ch !== 2'd2) begin n_fail++; $display("FAIL single_out: got v=%b d=%h ch=%0d want v=1 d=3c ch=2", bus_r.o_valid, bus_r.o_data, bus_r.o_ch); end
    bus_r.in_data  = STD_DATA;
    bus_r.in_valid = 4'b1111;
    #1;
    n_tests++; if (bus_r.in_ready !== 4'b1000) begin n_fail++; $display("FAIL single_ptr3: got in_ready=%b want 1000", bus_r.in_ready); end
    step();
    n_tests++; if (bus_r.o_ch !== 2'd3 || bus_r.o_data !== 8'h43) begin n_fail++; $display("FAIL single_next: got ch=%0d d=%h want ch=3 d=43", bus_r.o_ch, bus_r.o_data); end
    bus_r.in_valid = 4'b0000;
    step();
    n_tests++; if (bus_r.o_valid !== 1'b0 || bus_r.o_data !== 8'h43 || bus_r.o_ch !== 2'd3) begin n_fail++; $display("FAIL single_drain: got v=%b d=%h ch=%0d want v=0 d=43 ch=3", bus_r.o_valid, bus_r.o_data, bus_r.o_ch); end
  endtask

  task automatic test_rotation();
    logic [7:0] exp_d [4];
    logic [1:0] ec;
    exp_d = '{8'h10, 8'h21, 8'h32, 8'h43};
    do_reset();
    bus_r.o_ready  = 1'b1;
    bus_r.in_data  = STD_DATA;
    bus_r.in_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      step();
      ec = 2'(i % 4);
      n_tests++; if (bus_r.o_valid !== 1'b1 || bus_r.o_ch !== ec || bus_r.o_data !== exp_d[i % 4]) begin n_fail++; $display("FAIL rotation_%0d: got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h", i, bus_r.o_valid, bus_r.o_ch, bus_r.o_data, ec, exp_d[i % 4]); end
    end
    bus_r.in_valid = 4'b0000;
    step();
  endtask

  task automatic test_backpressure();
    do_reset();
    bus_r.o_ready  = 1'b1;
    bus_r.in_data  = STD_DATA;
    bus_r.in_valid = 4'b0010;
    step();
    n_tests++; if (bus_r.o_data !== 8'h21 || bus_r.o_ch !== 2'd1) begin n_fail++; $display("FAIL bp_load: got d=%h ch=%0d want d=21 ch=1", bus_r.o_data, bus_r.o_ch); end
    bus_r.in_valid = 4'b0001;
    bus_r.o_ready  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (bus_r.in_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready_%0d: got %b want 0000", i, bus_r.in_ready); end
      step();
      n_tests++; if (bus_r.o_valid !== 1'b1 || bus_r.o_data !== 8'h21 || bus_r.o_ch !== 2'd1) begin n_fail++; $display("FAIL bp_hold_%0d: got v=%b d=%h ch=%0d want v=1 d=21 ch=1", i, bus_r.o_valid, bus_r.o_data, bus_r.o_ch); end
    end
    bus_r.o_ready = 1'b1;
    #1;
    n_tests++; if (bus_r.in_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_release_ready: got %b want 0001", bus_r.in_ready); end
    step();
    n_tests++; if (bus_r.o_valid !== 1'b1 || bus_r.o_data !== 8'h10 || bus_r.o_ch !== 2'd0) begin n_fail++; $display("FAIL bp_release_out: got v=%b d=%h ch=%0d want v=1 d=10 ch=0", bus_r.o_valid, bus_r.o_data, bus_r.o_ch); end
    bus_r.in_valid = 4'b0000;
    step();
  endtask

  task automatic test_wrap_skip();
    logic [7:0] exp_d [4];
    logic [1:0] g;
    logic [3:0] er;
    exp_d = '{8'h10, 8'h21, 8'h32, 8'h43};
    do_reset();
    bus_r.o_ready  = 1'b1;
    bus_r.in_data  = STD_DATA;
    bus_r.in_valid = 4'b0100;
    step();
    n_tests++; if (bus_r.o_ch !== 2'd2) begin n_fail++; $display("FAIL wrap_setup: got ch=%0d want 2", bus_r.o_ch); end
    bus_r.in_valid = 4'b0000;
    step();
    n_tests++; if (bus_r.o_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_idle: got o_valid=%b want 0", bus_r.o_valid); end
    bus_r.in_valid = 4'b0011;
    for (int j = 0; j < 3; j++) begin
      g  = (j == 1) ? 2'd1 : 2'd0;
      er = 4'b0001 << g;
      #1;
      n_tests++; if (bus_r.in_ready !== er) begin n_fail++; $display("FAIL wrap_ready_%0d: got %b want %b", j, bus_r.in_ready, er); end
      step();
      n_tests++; if (bus_r.o_valid !== 1'b1 || bus_r.o_ch !== g || bus_r.o_data !== exp_d[g]) begin n_fail++; $display("FAIL wrap_out_%0d: got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h", j, bus_r.o_valid, bus_r.o_ch, bus_r.o_data, g, exp_d[g]); end
    end
    bus_r.in_valid = 4'b0000;
    step();
  endtask

  task automatic test_fixed();
    do_reset();
    bus_f.o_ready  = 1'b1;
    bus_f.in_data  = STD_DATA;
    bus_f.in_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++; if (bus_f.o_valid !== 1'b1 || bus_f.o_ch !== 2'd0 || bus_f.o_data !== 8'h10) begin n_fail++; $display("FAIL fixed_ch0_%0d: got v=%b ch=%0d d=%h want v=1 ch=0 d=10", i, bus_f.o_valid, bus_f.o_ch, bus_f.o_data); end
    end
    bus_f.in_valid = 4'b1110;
    #1;
    n_tests++; if (bus_f.in_ready !== 4'b0010) begin n_fail++; $display("FAIL fixed_ready: got %b want 0010", bus_f.in_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++; if (bus_f.o_ch !== 2'd1 || bus_f.o_data !== 8'h21) begin n_fail++; $display("FAIL fixed_ch1_%0d: got ch=%0d d=%h want ch=1 d=21", i, bus_f.o_ch, bus_f.o_data); end
    end
    bus_f.in_valid = 4'b0000;
    step();
  endtask

  task automatic test_nch3();
    logic [7:0] exp_d [3];
    logic [1:0] ec;
    exp_d = '{8'hA0, 8'hB1, 8'hC2};
    do_reset();
    bus_3.o_ready  = 1'b1;
    bus_3.in_data  = {8'hC2, 8'hB1, 8'hA0};
    bus_3.in_valid = 3'b111;
    for (int i = 0; i < 6; i++) begin
      step();
      ec = 2'(i % 3);
      n_tests++; if (bus_3.o_valid !== 1'b1 || bus_3.o_ch !== ec || bus_3.o_data !== exp_d[i % 3]) begin n_fail++; $display("FAIL nch3_%0d: got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h", i, bus_3.o_valid, bus_3.o_ch, bus_3.o_data, ec, exp_d[i % 3]); end
    end
    bus_3.in_valid = 3'b000;
    step();
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b0;
    n_tests = 0;
    n_fail  = 0;
    bus_r.in_valid = '0; bus_r.in_data = '0; bus_r.o_ready = 1'b1;
    bus_f.in_valid = '0; bus_f.in_data = '0; bus_f.o_ready = 1'b1;
    bus_3.in_valid = '0; bus_3.in_data = '0; bus_3.o_ready = 1'b1;
    #2 rst = 1'b1;
    test_reset();
    test_single();
    test_rotation();
    test_backpressure();
    test_wrap_skip();
    test_fixed();
    test_nch3();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
